// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: round-robin share of one per-thread data-memory port among a core's warps
// Ports: clk; reset (async, active-low); warp_req_* in / warp_req_ready out (grant pulse);
// warp_resp_valid/warp_resp_data out (completion pulse + load data); data_mem_read_* and
// data_mem_write_* per-thread channels. Define CORE_MEM_ARB_STATS_EN to add stat_busy_cycles.
module core_mem_arbiter #(
  parameter int WARPS_PER_CORE = 4,
  parameter int THREADS_PER_WARP = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
`ifdef CORE_MEM_ARB_STATS_EN
  output logic [31:0] stat_busy_cycles,
`endif
  input  logic [WARPS_PER_CORE-1:0] warp_req_valid,
  input  logic [WARPS_PER_CORE-1:0] warp_req_write,
  input  logic [WARPS_PER_CORE-1:0][THREADS_PER_WARP-1:0] warp_req_mask,
  input  logic [WARPS_PER_CORE-1:0][THREADS_PER_WARP-1:0][ADDR_WIDTH-1:0] warp_req_addr,
  input  logic [WARPS_PER_CORE-1:0][THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] warp_req_wdata,
  output logic [WARPS_PER_CORE-1:0] warp_req_ready,
  output logic [WARPS_PER_CORE-1:0] warp_resp_valid,
  output logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] warp_resp_data,
  output logic [THREADS_PER_WARP-1:0] data_mem_read_valid,
  output logic [THREADS_PER_WARP-1:0][ADDR_WIDTH-1:0] data_mem_read_address,
  input  logic [THREADS_PER_WARP-1:0] data_mem_read_ready,
  input  logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] data_mem_read_data,
  output logic [THREADS_PER_WARP-1:0] data_mem_write_valid,
  output logic [THREADS_PER_WARP-1:0][ADDR_WIDTH-1:0] data_mem_write_address,
  output logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] data_mem_write_data,
  input  logic [THREADS_PER_WARP-1:0] data_mem_write_ready
);
  localparam int WW = WARPS_PER_CORE > 1 ? $clog2(WARPS_PER_CORE) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;
  state_t state, next;
  logic [WW-1:0] last_grant, gnt_idx;
  logic gnt_any;
  logic [2*WARPS_PER_CORE-1:0] dbl;
  logic lat_write;
  logic [THREADS_PER_WARP-1:0] lat_mask, pending, done;
  logic [THREADS_PER_WARP-1:0][ADDR_WIDTH-1:0] lat_addr;
  logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] lat_wdata, resp_data;
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    dbl = {warp_req_valid, warp_req_valid} >> ((int'(last_grant) + 1) % WARPS_PER_CORE);
    for (int i = WARPS_PER_CORE - 1; i >= 0; i--)
      if (dbl[i]) begin
        gnt_any = 1'b1;
        gnt_idx = WW'((int'(last_grant) + 1 + i) % WARPS_PER_CORE);
      end
  end
  assign done = state == ACCESS ? pending & (lat_write ? data_mem_write_ready : data_mem_read_ready) : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next;
  always_comb
    next = state == IDLE ? (gnt_any ? (|warp_req_mask[gnt_idx] ? ACCESS : RESPOND) : IDLE) :
           state == ACCESS ? ((pending & ~done) == '0 ? RESPOND : ACCESS) : IDLE;
  always_comb begin
    warp_req_ready = reset && state == IDLE && gnt_any ? WARPS_PER_CORE'(1) << gnt_idx : '0;
    warp_resp_valid = state == RESPOND ? WARPS_PER_CORE'(1) << last_grant : '0;
    warp_resp_data = state == RESPOND && lat_write ? '0 : resp_data;
    data_mem_read_valid = state == ACCESS && !lat_write ? pending : '0;
    data_mem_write_valid = state == ACCESS && lat_write ? pending : '0;
    data_mem_read_address = lat_addr;
    data_mem_write_address = lat_addr;
    data_mem_write_data = lat_wdata;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      last_grant <= WW'(WARPS_PER_CORE - 1);
      lat_write <= 1'b0;
      lat_mask <= '0;
      pending <= '0;
      lat_addr <= '0;
      lat_wdata <= '0;
      resp_data <= '0;
    end else if (state == IDLE && gnt_any) begin
      last_grant <= gnt_idx;
      lat_write <= warp_req_write[gnt_idx];
      lat_mask <= warp_req_mask[gnt_idx];
      pending <= warp_req_mask[gnt_idx];
      lat_addr <= warp_req_addr[gnt_idx];
      lat_wdata <= warp_req_wdata[gnt_idx];
      if (!warp_req_write[gnt_idx] && warp_req_mask[gnt_idx] == '0) resp_data <= '0;
    end else if (state == ACCESS) begin
      pending <= pending & ~done;
      for (int t = 0; t < THREADS_PER_WARP; t++)
        resp_data[t] <= lat_write ? resp_data[t] :
                        done[t] ? data_mem_read_data[t] :
                        next == RESPOND && !lat_mask[t] ? '0 : resp_data[t];
    end
`ifdef CORE_MEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) stat_busy_cycles <= '0;
    else if (state != IDLE && stat_busy_cycles != 32'hFFFF_FFFF) stat_busy_cycles <= stat_busy_cycles + 32'd1;
`endif
endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: directed self-checking bench for core_mem_arbiter
module tb_core_mem_arbiter;
  logic clk, reset;
  logic [3:0] warp_req_valid, warp_req_write, warp_req_ready, warp_resp_valid;
  logic [3:0][31:0] warp_req_mask;
  logic [3:0][31:0][7:0] warp_req_addr;
  logic [3:0][31:0][15:0] warp_req_wdata;
  logic [31:0][15:0] warp_resp_data, data_mem_read_data, data_mem_write_data;
  logic [31:0][7:0] data_mem_read_address, data_mem_write_address;
  logic [31:0] data_mem_read_valid, data_mem_read_ready, data_mem_write_valid, data_mem_write_ready;
`ifdef CORE_MEM_ARB_STATS_EN
  logic [31:0] stat_busy_cycles;
`endif
  int n_cmp = 0, n_bad = 0;
  core_mem_arbiter dut (
    .clk(clk),
    .reset(reset),
`ifdef CORE_MEM_ARB_STATS_EN
    .stat_busy_cycles(stat_busy_cycles),
`endif
    .warp_req_valid(warp_req_valid),
    .warp_req_write(warp_req_write),
    .warp_req_mask(warp_req_mask),
    .warp_req_addr(warp_req_addr),
    .warp_req_wdata(warp_req_wdata),
    .warp_req_ready(warp_req_ready),
    .warp_resp_valid(warp_resp_valid),
    .warp_resp_data(warp_resp_data),
    .data_mem_read_valid(data_mem_read_valid),
    .data_mem_read_address(data_mem_read_address),
    .data_mem_read_ready(data_mem_read_ready),
    .data_mem_read_data(data_mem_read_data),
    .data_mem_write_valid(data_mem_write_valid),
    .data_mem_write_address(data_mem_write_address),
    .data_mem_write_data(data_mem_write_data),
    .data_mem_write_ready(data_mem_write_ready)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  initial begin
    reset = 1'b0;
    warp_req_valid = '0;
    warp_req_write = '0;
    warp_req_mask = '0;
    warp_req_addr = '0;
    warp_req_wdata = '0;
    data_mem_read_ready = '0;
    data_mem_read_data = '0;
    data_mem_write_ready = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", warp_req_ready, 0);
    chk("rst_resp", warp_resp_valid, 0);
    chk("rst_rvalid", data_mem_read_valid, 0);
    chk("rst_wvalid", data_mem_write_valid, 0);
    chk("rst_rdata", 64'(warp_resp_data == '0), 1);
    chk("rst_waddr", 64'(data_mem_write_address == '0), 1);
    reset = 1'b1;
    warp_req_valid = 4'b0001;
    warp_req_mask[0] = 32'h3;
    warp_req_addr[0][0] = 8'h10;
    warp_req_addr[0][1] = 8'h11;
    #1 chk("ld_grant", warp_req_ready, 4'b0001);
    @(negedge clk);
    warp_req_valid = '0;
    chk("ld_rvalid", data_mem_read_valid, 32'h3);
    chk("ld_wvalid", data_mem_write_valid, 0);
    chk("ld_addr0", data_mem_read_address[0], 8'h10);
    chk("ld_addr1", data_mem_read_address[1], 8'h11);
    data_mem_read_ready = 32'h3;
    data_mem_read_data[0] = 16'hAAAA;
    data_mem_read_data[1] = 16'hBBBB;
    @(negedge clk);
    data_mem_read_ready = '0;
    chk("ld_resp", warp_resp_valid, 4'b0001);
    chk("ld_data0", warp_resp_data[0], 16'hAAAA);
    chk("ld_data1", warp_resp_data[1], 16'hBBBB);
    chk("ld_data2", warp_resp_data[2], 0);
    chk("ld_rvalid_off", data_mem_read_valid, 0);
    @(negedge clk);
    chk("ld_resp_once", warp_resp_valid, 0);
`ifdef CORE_MEM_ARB_STATS_EN
    chk("ld_stat", stat_busy_cycles, 2);
`endif
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    data_mem_read_ready = '1;
    data_mem_read_data[0] = 16'h1234;
    for (int w = 0; w < 4; w++) warp_req_mask[w] = 32'h1;
    warp_req_valid = 4'hF;
    for (int g = 0; g < 6; g++) begin
      #1 chk("rr_grant", warp_req_ready, 64'(1) << (g % 4));
      chk("rr_idle_resp", warp_resp_valid, 0);
      @(negedge clk);
      chk("rr_rvalid", data_mem_read_valid, 1);
      chk("rr_no_overlap", warp_req_ready, 0);
      @(negedge clk);
      chk("rr_resp", warp_resp_valid, 64'(1) << (g % 4));
      chk("rr_data", warp_resp_data[0], 16'h1234);
      chk("rr_resp_ready", warp_req_ready, 0);
      if (g == 5) begin
        warp_req_valid = '0;
        data_mem_read_ready = '0;
      end
      @(negedge clk);
    end
    warp_req_valid = 4'b0001;
    warp_req_write = 4'b0001;
    warp_req_mask[0] = 32'hF;
    for (int t = 0; t < 4; t++) begin
      warp_req_addr[0][t] = 8'(8'h20 + t);
      warp_req_wdata[0][t] = 16'(16'h5000 + t);
    end
    #1 chk("st_grant", warp_req_ready, 4'b0001);
    @(negedge clk);
    warp_req_valid = '0;
    chk("st_wvalid_f", data_mem_write_valid, 32'hF);
    chk("st_rvalid", data_mem_read_valid, 0);
    chk("st_waddr3", data_mem_write_address[3], 8'h23);
    chk("st_wdata2", data_mem_write_data[2], 16'h5002);
    data_mem_write_ready = 32'h8;
    @(negedge clk);
    chk("st_wvalid_7", data_mem_write_valid, 32'h7);
    data_mem_write_ready = 32'h29;
    @(negedge clk);
    chk("st_wvalid_6", data_mem_write_valid, 32'h6);
    data_mem_write_ready = 32'h4;
    @(negedge clk);
    chk("st_wvalid_2", data_mem_write_valid, 32'h2);
    chk("st_early_resp", warp_resp_valid, 0);
    data_mem_write_ready = 32'h2;
    @(negedge clk);
    data_mem_write_ready = '0;
    chk("st_wvalid_0", data_mem_write_valid, 0);
    chk("st_resp", warp_resp_valid, 4'b0001);
    chk("st_data", warp_resp_data[0], 0);
    chk("st_rvalid_end", data_mem_read_valid, 0);
    @(negedge clk);
    chk("st_resp_once", warp_resp_valid, 0);
    warp_req_valid = 4'b0100;
    warp_req_write = '0;
    warp_req_mask[2] = '0;
    #1 chk("zm_grant", warp_req_ready, 4'b0100);
    @(negedge clk);
    warp_req_valid = '0;
    chk("zm_resp", warp_resp_valid, 4'b0100);
    chk("zm_rvalid", data_mem_read_valid, 0);
    chk("zm_wvalid", data_mem_write_valid, 0);
    chk("zm_data", 64'(warp_resp_data == '0), 1);
    @(negedge clk);
    warp_req_valid = 4'b0010;
    warp_req_mask[1] = 32'hFF;
    #1 chk("mr_grant", warp_req_ready, 4'b0010);
    @(negedge clk);
    chk("mr_rvalid", data_mem_read_valid, 32'hFF);
    warp_req_valid = 4'b1010;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      chk("mr_no_resp", warp_resp_valid, 0);
      chk("mr_no_grant", warp_req_ready, 0);
    end
    reset = 1'b0;
    #1 chk("mr_rvalid_rst", data_mem_read_valid, 0);
    chk("mr_wvalid_rst", data_mem_write_valid, 0);
    chk("mr_resp_rst", warp_resp_valid, 0);
    chk("mr_ready_rst", warp_req_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("mr_regrant", warp_req_ready, 4'b0010);
    chk("mr_resp_rel", warp_resp_valid, 0);
    @(negedge clk);
    warp_req_valid = '0;
    chk("mr_reaccess", data_mem_read_valid, 32'hFF);
    chk("mr_resp_after", warp_resp_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shares one compute core's per-thread data-memory port among the core's warps; each warp's load/store unit is one requester.
- Round-robin grant of a whole-warp access, then drives the per-thread read or write channel.
- Collects completions and returns read data and a one-cycle response to the granted warp.
- Sits between the warp LSUs and the core's data_mem_* interface.

Parameters:
- WARPS_PER_CORE, 4, number of requesting warps (1..16).
- THREADS_PER_WARP, 32, lanes per access (1..32).
- ADDR_WIDTH, 8, data-memory address width.
- DATA_WIDTH, 16, data word width.

Ports:
- clk  input  1  core clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = in reset.
- warp_req_valid  input  [WARPS_PER_CORE]  warp w requests an access; held until accepted.
- warp_req_write  input  [WARPS_PER_CORE]  1 = store, 0 = load.
- warp_req_mask  input  [WARPS_PER_CORE][THREADS_PER_WARP]  active-thread mask.
- warp_req_addr  input  [WARPS_PER_CORE][THREADS_PER_WARP][ADDR_WIDTH]  per-thread address.
- warp_req_wdata  input  [WARPS_PER_CORE][THREADS_PER_WARP][DATA_WIDTH]  per-thread store data.
- warp_req_ready  output  [WARPS_PER_CORE]  one-hot, 1-cycle pulse: request captured.
- warp_resp_valid  output  [WARPS_PER_CORE]  one-hot, 1-cycle pulse: access complete.
- warp_resp_data  output  [THREADS_PER_WARP][DATA_WIDTH]  load data; valid with warp_resp_valid.
- data_mem_read_valid  output  [THREADS_PER_WARP]  per-thread read request.
- data_mem_read_address  output  [THREADS_PER_WARP][ADDR_WIDTH]  read address.
- data_mem_read_ready  input  [THREADS_PER_WARP]  read done; data valid this cycle.
- data_mem_read_data  input  [THREADS_PER_WARP][DATA_WIDTH]  read data.
- data_mem_write_valid  output  [THREADS_PER_WARP]  per-thread write request.
- data_mem_write_address  output  [THREADS_PER_WARP][ADDR_WIDTH]  write address.
- data_mem_write_data  output  [THREADS_PER_WARP][DATA_WIDTH]  write data.
- data_mem_write_ready  input  [THREADS_PER_WARP]  write accepted.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all valid/ready/resp outputs 0; address/data outputs and warp_resp_data 0.
  - Priority pointer reset so warp 0 has highest priority.
  - Reset mid-access drops the access silently; no response is issued.
- FSM IDLE, ACCESS, RESPOND.
- IDLE:
  - Grant the first w with warp_req_valid[w]=1, searching from (last_grant+1) mod WARPS_PER_CORE upward with wrap.
  - Same cycle: warp_req_ready[w]=1, latch write/mask/addr/wdata into internal regs, last_grant<=w.
  - If latched mask is all-zero go to RESPOND, else ACCESS. No request: stay IDLE.
- ACCESS:
  - From the cycle after grant, assert data_mem_read_valid[t] (load) or data_mem_write_valid[t] (store) for every pending masked thread t. Unmasked threads stay 0.
  - Address/data outputs come from latched regs only; requester inputs may change after accept.
  - Handshake completes on valid[t]&ready[t] in the same cycle.
  - Completion clears pending[t] and drops valid[t] the next cycle. Loads also latch data_mem_read_data[t] into warp_resp_data[t].
  - ready on an unasserted lane is ignored. Lanes complete independently and in any order.
  - When the last pending lane completes, go to RESPOND next cycle.
- RESPOND:
  - warp_resp_valid[last_grant]=1 for exactly one cycle, then IDLE.
  - warp_resp_data holds through the pulse and until the next load's lane captures. Unmasked lanes return 0.
  - Store responses carry data 0.
- Latency: grant at cycle N, channel valids at N+1; memory ready at N+1 gives response at N+2. Zero-mask access gives response at N+1.
- Next grant is earliest in the cycle after RESPOND (one access in flight; no overlap).
- The granted warp's warp_req_valid is ignored until its response. Warps re-requesting are served in rotation, so no warp starves.
- Read and write valids are never asserted together.

Optional Feature:
- Macro CORE_MEM_ARB_STATS_EN.
- When defined, adds output stat_busy_cycles (32 bits). It increments every cycle state≠IDLE, saturates at 0xFFFFFFFF and resets to 0.
- When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
- Single load: warp 0 load, mask 0x0000_0003, addr lane0=0x10, lane1=0x11; memory gives ready same cycle as valid with data 0xAAAA/0xBBBB. Required: read_valid=0x3 at N+1, warp_resp_valid=0b0001 at N+2, resp_data lane0=0xAAAA, lane1=0xBBBB, other lanes 0.
- Round-robin: all four warps hold valid continuously, every access single-lane with immediate ready. Required: grants 0,1,2,3,0,1 in order, one response per grant, never two accesses overlapped.
- Out-of-order lanes: store, mask 0xF; write_ready for lanes 3, 0, 2, 1 on successive cycles. Required: each lane's write_valid drops the cycle after its ready; response exactly one cycle after lane 1 completes; read_valid stays 0.
- Zero mask: warp 2 request with mask 0. Required: warp_req_ready[2] at N, warp_resp_valid[2] at N+1, no data_mem valids asserted.
- Mid-access reset: warp 1 load, mask 0xFF, memory never ready; pull reset low for 1 cycle at ACCESS cycle 5. Required: all valids 0 immediately (asynchronous); no warp_resp_valid; after release, pending warp 3 request granted ahead of warp 1's re-request only if warp 0 is idle and the pointer order (0 first) says so.
- With CORE_MEM_ARB_STATS_EN: the single-load case leaves stat_busy_cycles=2.
